// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad (PmodKYPD pinout), debounces press
// and release, and presents a level 'press' plus the hex code of the accepted key.
// Optional feature: define KEYPAD_SYNC_EN to pass 'row' through a 2-flop
// synchroniser first; every row-related latency then grows by 2 cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   SCAN     | drive one column low, sample rows at the end of each slot
//   DEBOUNCE | column frozen, waiting for the captured row pattern to hold
//   HELD     | key accepted, press=1, waiting for all rows high
//   RELEASE  | all rows high, waiting for the release to hold
module keypad_scanner #(
  parameter int SCAN_DIV   = 5000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       press,
  output logic [3:0] key
);

  localparam int MAXC = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  logic [3:0] row_s;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  // Two-flop synchroniser; idles at all-high so reset looks like "no key".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  assign row_s = sync2_q;
`else
  assign row_s = row;
`endif

  state_t        state_q, state_d;
  logic [3:0]    col_q, col_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic          press_q, press_d;
  logic [3:0]    key_q, key_d;

  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [3:0] key_lut;

  // Key code for the captured pattern: lowest asserted row wins.
  always_comb begin
    row_idx = 2'd3;
    if (!cap_q[0])      row_idx = 2'd0;
    else if (!cap_q[1]) row_idx = 2'd1;
    else if (!cap_q[2]) row_idx = 2'd2;

    case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase

    case ({row_idx, col_idx})
      4'h0:    key_lut = 4'h1;
      4'h1:    key_lut = 4'h2;
      4'h2:    key_lut = 4'h3;
      4'h3:    key_lut = 4'hA;
      4'h4:    key_lut = 4'h4;
      4'h5:    key_lut = 4'h5;
      4'h6:    key_lut = 4'h6;
      4'h7:    key_lut = 4'hB;
      4'h8:    key_lut = 4'h7;
      4'h9:    key_lut = 4'h8;
      4'hA:    key_lut = 4'h9;
      4'hB:    key_lut = 4'hC;
      4'hC:    key_lut = 4'h0;
      4'hD:    key_lut = 4'hF;
      4'hE:    key_lut = 4'hE;
      default: key_lut = 4'hD;
    endcase
  end

  // Next-state logic; leaving the frozen column always advances it and restarts the slot.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    press_d = press_q;
    key_d   = key_q;

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          if (row_s == 4'hF) begin
            col_d = {col_q[2:0], col_q[3]};
            div_d = '0;
          end else begin
            cap_d   = row_s;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_s == cap_q) begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_HELD;
            press_d = 1'b1;
            key_d   = key_lut;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_SCAN;
          col_d   = {col_q[2:0], col_q[3]};
          div_d   = '0;
        end
      end

      ST_HELD: begin
        if (row_s == 4'hF) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      ST_RELEASE: begin
        if (row_s == 4'hF) begin
          if (cnt_q == DEB_LAST) begin
            state_d = ST_SCAN;
            press_d = 1'b0;
            col_d   = {col_q[2:0], col_q[3]};
            div_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_HELD;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SCAN;
      col_q   <= 4'b1110;
      div_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= 4'hF;
      press_q <= 1'b0;
      key_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      press_q <= press_d;
      key_q   <= key_d;
    end
  end

  assign col   = col_q;
  assign press = press_q;
  assign key   = key_q;

endmodule
